// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the decode/operand-fetch stage.
// Holds the ALU function encodings and the two accepted RV32I opcodes.
package decode_stage_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int PEND_MAX_DEF = 3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_funct3_e;

  typedef enum logic [6:0] {
    ALU_PASS = 7'b0000000,
    ALU_NEG  = 7'b0100000
  } alu_funct7_e;

endpackage

// File: rtl/decode_stage_reg_file.sv
// Architectural register file: two async read ports, one sync write port.
// x0 reads as zero; a write in the same cycle is forwarded to the readers.
module decode_stage_reg_file
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 :
                  (we && waddr == raddr1) ? wdata : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 :
                  (we && waddr == raddr2) ? wdata : mem[raddr2];

endmodule

// File: rtl/decode_stage.sv
// Decode/operand-fetch stage: decodes OP/OP-IMM, reads operands, tracks
// in-flight writes per register and registers the execute payload.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int PEND_MAX = PEND_MAX_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output alu_funct3_e     funct3_o,
  output alu_funct7_e     funct7_o,
  output logic [4:0]      rd_o,
  output logic            illegal_o,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i
);

  localparam int PCW = $clog2(PEND_MAX + 1);

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic            is_op, is_op_imm, legal;
  logic [XLEN-1:0] rs1_data, rs2_data, imm;
  logic [PCW-1:0]  pend [NUM_REGS];
  logic            rs1_busy, rs2_busy, rd_full, hazard, accept;

  logic [XLEN-1:0] dec_op1, dec_op2;
  alu_funct3_e     dec_funct3;
  alu_funct7_e     dec_funct7;
  logic [4:0]      dec_rd;
  logic            dec_illegal;

  assign opcode    = instr_i[6:0];
  assign rd        = instr_i[11:7];
  assign rs1       = instr_i[19:15];
  assign rs2       = instr_i[24:20];
  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign legal     = is_op || is_op_imm;
  assign imm       = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};

  decode_stage_reg_file #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we     (wb_en_i),
    .waddr  (wb_rd_i),
    .wdata  (wb_data_i),
    .raddr1 (rs1),
    .rdata1 (rs1_data),
    .raddr2 (rs2),
    .rdata2 (rs2_data)
  );

  // A source whose only outstanding write lands this cycle is not busy:
  // the register file forwards that write to the read port.
  assign rs1_busy = (pend[rs1] != '0) &&
                    !(pend[rs1] == PCW'(1) && wb_en_i && wb_rd_i == rs1);
  assign rs2_busy = (pend[rs2] != '0) &&
                    !(pend[rs2] == PCW'(1) && wb_en_i && wb_rd_i == rs2);
  assign rd_full  = (pend[rd] == PCW'(PEND_MAX));
  assign hazard   = instr_valid_i && legal &&
                    (rs1_busy || (is_op && rs2_busy) || rd_full);

  // Handshake: a beat moves when valid && ready on a rising edge. The input
  // side is ready when the output slot is empty or draining and no hazard;
  // the output payload is held while ex_valid_o && !ex_ready_i.
  assign instr_ready_o = (!ex_valid_o || ex_ready_i) && !hazard;
  assign accept        = instr_valid_i && instr_ready_o;

  always_comb begin
    dec_illegal = 1'b0;
    dec_rd      = rd;
    dec_funct3  = alu_funct3_e'(instr_i[14:12]);
    dec_funct7  = ALU_PASS;
    dec_op1     = rs1_data;
    dec_op2     = rs2_data;
    if (is_op) begin
      if (instr_i[31:25] == ALU_NEG) dec_funct7 = ALU_NEG;
    end else if (is_op_imm) begin
      dec_op2 = imm;
      if (dec_funct3 == ALU_SR && instr_i[30]) dec_funct7 = ALU_NEG;
    end else begin
      dec_illegal = 1'b1;
      dec_rd      = '0;
      dec_funct3  = ALU_ADD;
      dec_op1     = '0;
      dec_op2     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_o <= 1'b0;
      op1_o      <= '0;
      op2_o      <= '0;
      funct3_o   <= ALU_ADD;
      funct7_o   <= ALU_PASS;
      rd_o       <= '0;
      illegal_o  <= 1'b0;
    end else if (accept) begin
      ex_valid_o <= 1'b1;
      op1_o      <= dec_op1;
      op2_o      <= dec_op2;
      funct3_o   <= dec_funct3;
      funct7_o   <= dec_funct7;
      rd_o       <= dec_rd;
      illegal_o  <= dec_illegal;
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

  // A decrement with nothing outstanding is a spurious writeback and is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if ((accept && legal && rd == 5'(r)) && !(wb_en_i && wb_rd_i == 5'(r)))
          pend[r] <= pend[r] + 1'b1;
        else if (!(accept && legal && rd == 5'(r)) && wb_en_i && wb_rd_i == 5'(r) &&
                 pend[r] != '0)
          pend[r] <= pend[r] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed hazard/backpressure cases
// followed by a random stream scored against an expected-payload queue.
module tb_decode_stage;

  localparam int XLEN = 32;
  localparam int PW   = 1 + 5 + 7 + 3 + 2 * XLEN;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            instr_valid_i;
  logic            instr_ready_o;
  logic [31:0]     instr_i;
  logic            ex_valid_o;
  logic            ex_ready_i;
  logic [XLEN-1:0] op1_o, op2_o;
  logic [2:0]      funct3_o;
  logic [6:0]      funct7_o;
  logic [4:0]      rd_o;
  logic            illegal_o;
  logic            wb_en_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;

  logic [PW-1:0]   obs_payload;
  logic [PW-1:0]   exp_q[$];
  logic [XLEN-1:0] model_regs [32];
  logic            exp_ev = 1'b0;
  int              checks = 0;
  int              errors = 0;
  int              xfers  = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .ex_valid_o    (ex_valid_o),
    .ex_ready_i    (ex_ready_i),
    .op1_o         (op1_o),
    .op2_o         (op2_o),
    .funct3_o      (funct3_o),
    .funct7_o      (funct7_o),
    .rd_o          (rd_o),
    .illegal_o     (illegal_o),
    .wb_en_i       (wb_en_i),
    .wb_rd_i       (wb_rd_i),
    .wb_data_i     (wb_data_i)
  );

  assign obs_payload = {illegal_o, rd_o, funct7_o, funct3_o, op2_o, op1_o};

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] reg_val(input logic [4:0] r);
    if (r == 5'd0) return '0;
    if (wb_en_i && wb_rd_i == r) return wb_data_i;
    return model_regs[r];
  endfunction

  function automatic logic [PW-1:0] model_out(input logic [31:0] ins);
    logic [6:0]      opc, f7;
    logic [4:0]      rd;
    logic [2:0]      f3;
    logic [XLEN-1:0] a, b;
    logic            ill;
    opc = ins[6:0];
    rd  = ins[11:7];
    f3  = ins[14:12];
    ill = 1'b0;
    a   = '0;
    b   = '0;
    f7  = 7'h00;
    if (opc == 7'b0110011) begin
      a  = reg_val(ins[19:15]);
      b  = reg_val(ins[24:20]);
      f7 = (ins[31:25] == 7'h20) ? 7'h20 : 7'h00;
    end else if (opc == 7'b0010011) begin
      a  = reg_val(ins[19:15]);
      b  = {{20{ins[31]}}, ins[31:20]};
      f7 = (f3 == 3'b101 && ins[30]) ? 7'h20 : 7'h00;
    end else begin
      ill = 1'b1;
      rd  = '0;
      f3  = '0;
    end
    return {ill, rd, f7, f3, b, a};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom();
    ins[11:7] = 5'd0;
    case ($urandom_range(0, 3))
      0: ins[31:25] = 7'h20;
      1: ins[31:25] = 7'h00;
      default: ;
    endcase
    case ($urandom_range(0, 4))
      0, 1:    ins[6:0] = 7'b0110011;
      2, 3:    ins[6:0] = 7'b0010011;
      default: ins[6:0] = 7'b1100011;
    endcase
    return ins;
  endfunction

  // Scoreboard / monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_i) begin
      exp_ev = 1'b0;
    end else begin
      check("ex_valid", ex_valid_o, exp_ev);
      if (ex_valid_o && ex_ready_i) begin
        if (exp_q.size() == 0) check("spurious_out", ex_valid_o, 0);
        else begin
          check("payload", obs_payload, exp_q.pop_front());
          xfers++;
        end
      end
      if (instr_valid_i && instr_ready_o) begin
        exp_q.push_back(model_out(instr_i));
        exp_ev = 1'b1;
      end else if (ex_ready_i) begin
        exp_ev = 1'b0;
      end
      if (wb_en_i && wb_rd_i != 5'd0) model_regs[wb_rd_i] = wb_data_i;
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic rst_pulse();
    rst_i = 1'b1;
    exp_q.delete();
    for (int r = 0; r < 32; r++) model_regs[r] = '0;
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [XLEN-1:0] d);
    wb_en_i = 1'b1; wb_rd_i = r; wb_data_i = d;
    @(posedge clk); #1;
    wb_en_i = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [31:0] ins, input logic must_be_ready);
    int waited;
    waited = 0;
    instr_i = ins;
    instr_valid_i = 1'b1;
    @(negedge clk);
    if (must_be_ready) check(tag, instr_ready_o, 1);
    while (!instr_ready_o && waited < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      waited++;
    end
    if (!instr_ready_o) check({tag, "_timeout"}, instr_ready_o, 1);
    @(posedge clk); #1;
    instr_valid_i = 1'b0;
  endtask

  task automatic expect_stall(input string tag, input logic [31:0] ins, input int n);
    instr_i = ins;
    instr_valid_i = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check(tag, instr_ready_o, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int x0;
    logic held;
    rst_i = 1'b1; instr_valid_i = 1'b0; instr_i = '0; ex_ready_i = 1'b1;
    wb_en_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
    for (int r = 0; r < 32; r++) model_regs[r] = '0;
    repeat (2) @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("reset_payload", obs_payload, 0);
    check("reset_ready", instr_ready_o, 1);
    @(posedge clk); #1;

    // Reset mid-operation discards held payload, registers and pending state.
    wb(5'd1, 32'h55);
    ex_ready_i = 1'b0;
    issue("pre_rst_issue", 32'h00100093, 1'b1);
    rst_pulse();
    ex_ready_i = 1'b1;
    @(negedge clk);
    check("rst_mid_payload", obs_payload, 0);
    @(posedge clk); #1;
    issue("rst_pend_clear", 32'h001084B3, 1'b1);

    // addi x1,x0,-5 then a reader of x1 stalls until x1 is written back.
    issue("addi_neg", 32'hFFB00093, 1'b1);
    expect_stall("raw_x1", 32'h00008533, 1);
    instr_valid_i = 1'b0;
    wb(5'd1, 32'h11);

    // sub x4,x2,x3 with R[2]=7, R[3]=3.
    wb(5'd2, 32'd7);
    wb(5'd3, 32'd3);
    issue("sub", 32'h40310233, 1'b1);

    // RAW on x5: released in the writeback cycle with bypassed data.
    issue("addi_x5", 32'h00000293, 1'b1);
    expect_stall("raw_x5", 32'h00528333, 2);
    wb_en_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'd9;
    @(negedge clk);
    check("raw_release", instr_ready_o, 1);
    @(posedge clk); #1;
    instr_valid_i = 1'b0; wb_en_i = 1'b0;

    // Backpressure: payload holds for 3 cycles, then one transfer.
    repeat (2) @(posedge clk); #1;
    ex_ready_i = 1'b0;
    issue("bp_first", 32'h00500593, 1'b1);
    instr_i = 32'h00600613;
    instr_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready", instr_ready_o, 0);
      check("bp_hold", obs_payload, exp_q[0]);
      @(posedge clk); #1;
    end
    x0 = xfers;
    ex_ready_i = 1'b1;
    @(negedge clk);
    check("bp_release", instr_ready_o, 1);
    @(posedge clk); #1;
    check("bp_xfer", xfers - x0, 1);
    instr_valid_i = 1'b0;

    // PEND_MAX on x7; illegal opcodes leave pending counts untouched.
    for (int k = 0; k < 3; k++) issue("x7_issue", 32'h00100393, 1'b1);
    expect_stall("x7_full", 32'h00100393, 2);
    instr_valid_i = 1'b0;
    wb(5'd7, 32'h77);
    issue("x7_after_wb", 32'h00100393, 1'b1);
    issue("illegal", 32'h0000007F, 1'b1);
    issue("illegal_rd8", 32'h0000047F, 1'b1);
    issue("x8_not_pend", 32'h008406B3, 1'b1);
    expect_stall("x7_still_full", 32'h00100393, 1);
    instr_valid_i = 1'b0;

    // Random stream with no destination registers, random writebacks.
    rst_pulse();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      held = instr_valid_i && !instr_ready_o;
      if (instr_valid_i) check("rnd_ready", instr_ready_o, !ex_valid_o || ex_ready_i);
      @(posedge clk); #1;
      ex_ready_i = ($urandom_range(0, 3) != 0);
      wb_en_i    = $urandom_range(0, 1);
      wb_rd_i    = 5'($urandom_range(0, 31));
      wb_data_i  = $urandom();
      if (!held) begin
        instr_valid_i = ($urandom_range(0, 2) != 0);
        instr_i       = rand_instr();
      end
    end
    instr_valid_i = 1'b0; wb_en_i = 1'b0; ex_ready_i = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
